// File: rtl/video_stream_gen.sv
`default_nettype none
// ============================================================================
// Module  : video_stream_gen
// Brief   : Test-pattern pixel stream source (do/de/hs/vs) with programmable
//           active size, inter-pixel gaps and blanking.
// Rev     : 1.0  initial release
// ============================================================================
module video_stream_gen #(
    parameter int PIXEL_WIDTH = 12,
    parameter int HBLANK      = 16,
    parameter int VBLANK      = 64,
    parameter int PIX_GAP     = 0,
    parameter int CHK_SHIFT   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [1:0]             pattern_sel,
    input  logic [PIXEL_WIDTH-1:0] const_val,
    input  logic [15:0]            width,
    input  logic [15:0]            height,
    output logic [PIXEL_WIDTH-1:0] do_o,
    output logic                   de_o,
    output logic                   hs_o,
    output logic                   vs_o,
    output logic                   busy_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_HBLANK = 2'd2,
        S_VBLANK = 2'd3
    } state_t;

    localparam logic [15:0] C_HB_LAST = 16'(HBLANK - 1);
    localparam logic [15:0] C_VB_LAST = 16'(VBLANK - 1);
    localparam logic [15:0] C_GAP     = 16'(PIX_GAP);

    state_t                 r_state, w_state;
    logic [15:0]            r_x, w_x;
    logic [15:0]            r_y, w_y;
    logic [15:0]            r_gap, w_gap;
    logic [15:0]            r_cnt, w_cnt;
    logic [15:0]            r_width, w_width;
    logic [15:0]            r_height, w_height;
    logic [1:0]             r_pat, w_pat;
    logic [PIXEL_WIDTH-1:0] r_do, w_do;
    logic                   r_de, w_de;
    logic                   r_hs, w_hs;
    logic                   r_vs, w_vs;
    logic                   r_busy, w_busy;
    logic [PIXEL_WIDTH-1:0] w_pix;
    logic                   w_start;
    logic                   w_next_line;
    logic                   w_next_frame;

    assign w_start = en && (width != 16'd0) && (height != 16'd0);

    always_comb begin
        w_pix = '0;
        case (r_pat)
            2'd0:    w_pix = r_x[PIXEL_WIDTH-1:0];
            2'd1:    w_pix = r_y[PIXEL_WIDTH-1:0];
            2'd2:    w_pix = {PIXEL_WIDTH{r_x[CHK_SHIFT] ^ r_y[CHK_SHIFT]}};
            default: w_pix = const_val;
        endcase
    end

    always_comb begin
        w_state      = r_state;
        w_x          = r_x;
        w_y          = r_y;
        w_gap        = r_gap;
        w_cnt        = r_cnt;
        w_width      = r_width;
        w_height     = r_height;
        w_pat        = r_pat;
        w_do         = r_do;
        w_de         = 1'b0;
        w_hs         = 1'b0;
        w_vs         = 1'b0;
        w_busy       = (r_state != S_IDLE);
        w_next_line  = 1'b0;
        w_next_frame = 1'b0;

        case (r_state)
            S_IDLE: w_next_frame = 1'b1;
            S_ACTIVE: begin
                if (r_gap != 16'd0) begin
                    w_gap = r_gap - 16'd1;
                end else begin
                    w_de = 1'b1;
                    w_hs = (r_x == 16'd0);
                    w_vs = (r_x == 16'd0) && (r_y == 16'd0);
                    w_do = w_pix;
                    if (r_x != r_width - 16'd1) begin
                        w_x   = r_x + 16'd1;
                        w_gap = C_GAP;
                    end else if (r_y != r_height - 16'd1) begin
                        if (HBLANK == 0) begin
                            w_next_line = 1'b1;
                        end else begin
                            w_state = S_HBLANK;
                            w_cnt   = C_HB_LAST;
                        end
                    end else begin
                        if (VBLANK == 0) begin
                            w_next_frame = 1'b1;
                        end else begin
                            w_state = S_VBLANK;
                            w_cnt   = C_VB_LAST;
                        end
                    end
                end
            end
            S_HBLANK: begin
                if (r_cnt == 16'd0) w_next_line = 1'b1;
                else                w_cnt = r_cnt - 16'd1;
            end
            S_VBLANK: begin
                if (r_cnt == 16'd0) w_next_frame = 1'b1;
                else                w_cnt = r_cnt - 16'd1;
            end
            default: w_state = S_IDLE;
        endcase

        if (w_next_line) begin
            w_state = S_ACTIVE;
            w_x     = 16'd0;
            w_y     = r_y + 16'd1;
            w_gap   = 16'd0;
        end

        // Frame geometry and pattern are captured only here, so mid-frame input changes are ignored
        if (w_next_frame) begin
            if (w_start) begin
                w_state  = S_ACTIVE;
                w_x      = 16'd0;
                w_y      = 16'd0;
                w_gap    = 16'd0;
                w_width  = width;
                w_height = height;
                w_pat    = pattern_sel;
            end else begin
                w_state = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_x      <= '0;
            r_y      <= '0;
            r_gap    <= '0;
            r_cnt    <= '0;
            r_width  <= '0;
            r_height <= '0;
            r_pat    <= '0;
            r_do     <= '0;
            r_de     <= 1'b0;
            r_hs     <= 1'b0;
            r_vs     <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_x      <= w_x;
            r_y      <= w_y;
            r_gap    <= w_gap;
            r_cnt    <= w_cnt;
            r_width  <= w_width;
            r_height <= w_height;
            r_pat    <= w_pat;
            r_do     <= w_do;
            r_de     <= w_de;
            r_hs     <= w_hs;
            r_vs     <= w_vs;
            r_busy   <= w_busy;
        end
    end

    assign do_o   = r_do;
    assign de_o   = r_de;
    assign hs_o   = r_hs;
    assign vs_o   = r_vs;
    assign busy_o = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_video_stream_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_video_stream_gen
// Brief   : Self-checking bench for video_stream_gen (continuous and gapped).
// Rev     : 1.0  initial release
// ============================================================================
module tb_video_stream_gen;

    localparam int HB = 16;
    localparam int VB = 64;
    localparam int NV = 11;

    typedef struct {
        logic        de;
        logic        hs;
        logic        vs;
        logic [11:0] d;
    } smp_t;

    typedef struct {
        logic [1:0]  pat;
        int          w;
        int          h;
        logic [11:0] cval;
        int          px;
        int          py;
        logic [11:0] expv;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [11:0] const_val = 12'd0;
    logic [15:0] width = 16'd0;
    logic [15:0] height = 16'd0;

    logic [11:0] do_a, do_b;
    logic        de_a, hs_a, vs_a, busy_a;
    logic        de_b, hs_b, vs_b, busy_b;
    logic        sel = 1'b0;
    logic [11:0] cur_do;
    logic        cur_de, cur_hs, cur_vs, cur_busy;

    int   errors = 0;
    int   checks = 0;
    smp_t q[$];
    vec_t vt[NV];

    always #5 clk = ~clk;

    video_stream_gen u_dut_a (
        .clk(clk), .rst(rst), .en(en), .pattern_sel(pattern_sel), .const_val(const_val),
        .width(width), .height(height), .do_o(do_a), .de_o(de_a), .hs_o(hs_a),
        .vs_o(vs_a), .busy_o(busy_a)
    );

    video_stream_gen #(.PIX_GAP(2)) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .pattern_sel(pattern_sel), .const_val(const_val),
        .width(width), .height(height), .do_o(do_b), .de_o(de_b), .hs_o(hs_b),
        .vs_o(vs_b), .busy_o(busy_b)
    );

    assign cur_do   = sel ? do_b   : do_a;
    assign cur_de   = sel ? de_b   : de_a;
    assign cur_hs   = sel ? hs_b   : hs_a;
    assign cur_vs   = sel ? vs_b   : vs_a;
    assign cur_busy = sel ? busy_b : busy_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic logic [11:0] model_pix(input logic [1:0] pat, input int x, input int y,
                                              input logic [11:0] cval);
        case (pat)
            2'd0:    return 12'(x % 4096);
            2'd1:    return 12'(y % 4096);
            2'd2:    return ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 12'hFFF : 12'h000;
            default: return cval;
        endcase
    endfunction

    // Expected per-cycle stream of one frame, from its first pixel to the end of vertical blanking
    task automatic build_frame(input logic [1:0] pat, input int w, input int h,
                               input logic [11:0] cval, input int gap);
        logic [11:0] last;
        smp_t        s;
        last = 12'd0;
        q.delete();
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                last = model_pix(pat, x, y, cval);
                s = '{1'b1, x == 0, (x == 0) && (y == 0), last};
                q.push_back(s);
                if (x < w - 1)
                    for (int g = 0; g < gap; g++) q.push_back('{1'b0, 1'b0, 1'b0, last});
            end
            for (int b = 0; b < ((y < h - 1) ? HB : VB); b++) q.push_back('{1'b0, 1'b0, 1'b0, last});
        end
    endtask

    task automatic wait_vs(output bit found, output int waited);
        found  = 1'b0;
        waited = 0;
        while (!found && waited < 300) begin
            @(negedge clk);
            waited++;
            if (cur_de === 1'b1 && cur_vs === 1'b1) found = 1'b1;
        end
        chk("vs_seen", 32'(found), 32'd1);
    endtask

    task automatic apply_start(input logic [1:0] pat, input int w, input int h, input logic [11:0] cval);
        rst = 1'b1;
        en  = 1'b0;
        repeat (2) @(negedge clk);
        pattern_sel = pat;
        width       = 16'(w);
        height      = 16'(h);
        const_val   = cval;
        en          = 1'b1;
        rst         = 1'b0;
    endtask

    task automatic check_frame(input logic s, input int gap, input logic [1:0] pat, input int w,
                               input int h, input logic [11:0] cval, input logic [1:0] n_pat,
                               input int n_w, input int n_h, input logic n_en,
                               input logic [11:0] n_cval, output int waited);
        bit found;
        sel = s;
        build_frame(pat, w, h, cval, gap);
        wait_vs(found, waited);
        if (!found) return;
        for (int i = 0; i < q.size(); i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("stream[%0d] pat%0d %0dx%0d gap%0d", i, pat, w, h, gap),
                32'({cur_de, cur_hs, cur_vs, cur_do}),
                32'({q[i].de, q[i].hs, q[i].vs, q[i].d}));
            if (i == 0) begin
                chk("busy_in_frame", 32'(cur_busy), 32'd1);
                pattern_sel = n_pat;
                width       = 16'(n_w);
                height      = 16'(n_h);
                en          = n_en;
            end
            if (i == q.size() - VB) const_val = n_cval;
        end
    endtask

    initial begin
        logic [1:0]  cp, np;
        int          cw, ch, nw, nh, wt, nvs, idx;
        logic [11:0] cc, nc;
        logic [6:0]  dev, hsv;
        bit          found;

        vt[0]  = '{2'd0, 4,    2, 12'h000, 0,    0, 12'h000};
        vt[1]  = '{2'd0, 4,    2, 12'h000, 3,    1, 12'h003};
        vt[2]  = '{2'd2, 16,   9, 12'h000, 0,    0, 12'h000};
        vt[3]  = '{2'd2, 16,   9, 12'h000, 7,    0, 12'h000};
        vt[4]  = '{2'd2, 16,   9, 12'h000, 8,    0, 12'hFFF};
        vt[5]  = '{2'd2, 16,   9, 12'h000, 15,   0, 12'hFFF};
        vt[6]  = '{2'd2, 16,   9, 12'h000, 0,    8, 12'hFFF};
        vt[7]  = '{2'd2, 16,   9, 12'h000, 8,    8, 12'h000};
        vt[8]  = '{2'd1, 16,   9, 12'h000, 3,    5, 12'h005};
        vt[9]  = '{2'd3, 4,    2, 12'hA5C, 2,    1, 12'hA5C};
        vt[10] = '{2'd0, 4100, 1, 12'h000, 4097, 0, 12'h001};

        repeat (3) @(negedge clk);
        chk("reset_a", 32'({de_a, hs_a, vs_a, busy_a, do_a}), 32'd0);
        chk("reset_b", 32'({de_b, hs_b, vs_b, busy_b, do_b}), 32'd0);

        sel = 1'b0;
        for (int i = 0; i < NV; i++) begin
            apply_start(vt[i].pat, vt[i].w, vt[i].h, vt[i].cval);
            wait_vs(found, wt);
            repeat (vt[i].py * (vt[i].w + HB) + vt[i].px) @(negedge clk);
            chk($sformatf("tbl[%0d] pixel(%0d,%0d)", i, vt[i].px, vt[i].py),
                32'({cur_de, cur_do}), 32'({1'b1, vt[i].expv}));
        end

        // Back-to-back frames with sizes/pattern changed mid-frame
        cp = 2'd0; cw = 4; ch = 2; cc = 12'h000;
        apply_start(cp, cw, ch, cc);
        for (int f = 0; f < 7; f++) begin
            if (f == 6) begin
                np = 2'd0; nw = 5; nh = 4; nc = 12'h123;
            end else begin
                np = 2'($urandom_range(0, 3));
                nw = int'($urandom_range(1, 20));
                nh = int'($urandom_range(1, 12));
                nc = 12'($urandom);
            end
            check_frame(1'b0, 0, cp, cw, ch, cc, np, nw, nh, 1'b1, nc, wt);
            chk(f == 0 ? "start_latency" : "b2b_gap", 32'(wt), (f == 0) ? 32'd2 : 32'd1);
            cp = np; cw = nw; ch = nh; cc = nc;
        end

        check_frame(1'b0, 0, 2'd0, 5, 4, 12'h123, 2'd1, 3, 2, 1'b0, 12'h123, wt);
        chk("en_drop_b2b", 32'(wt), 32'd1);
        @(negedge clk);
        chk("busy_fall", 32'({cur_busy, cur_de}), 32'd0);
        nvs = 0;
        repeat (300) begin
            @(negedge clk);
            if (vs_a === 1'b1) nvs++;
        end
        chk("no_vs_after_stop", 32'(nvs), 32'd0);
        en = 1'b1;
        check_frame(1'b0, 0, 2'd1, 3, 2, 12'h123, 2'd1, 3, 2, 1'b0, 12'h123, wt);
        chk("restart_latency", 32'(wt), 32'd2);

        apply_start(2'd0, 0, 3, 12'h000);
        nvs = 0;
        repeat (150) begin
            @(negedge clk);
            if (de_a !== 1'b0 || busy_a !== 1'b0) nvs++;
        end
        chk("zero_width_idle", 32'(nvs), 32'd0);
        width = 16'd1; height = 16'd1;
        check_frame(1'b0, 0, 2'd0, 1, 1, 12'h000, 2'd0, 1, 1, 1'b0, 12'h000, wt);
        chk("single_pixel_latency", 32'(wt), 32'd2);

        apply_start(2'd0, 8, 2, 12'h000);
        wait_vs(found, wt);
        repeat (2) @(negedge clk);
        chk("pixel2_before_rst", 32'({de_a, do_a}), 32'({1'b1, 12'h002}));
        rst = 1'b1;
        #1;
        chk("async_reset", 32'({de_a, hs_a, vs_a, busy_a, do_a}), 32'd0);
        apply_start(2'd0, 8, 2, 12'h000);
        check_frame(1'b0, 0, 2'd0, 8, 2, 12'h000, 2'd0, 8, 2, 1'b0, 12'h000, wt);
        chk("restart_after_rst", 32'(wt), 32'd2);

        // Gapped instance: de cadence and line period
        sel = 1'b1;
        apply_start(2'd0, 3, 2, 12'h000);
        wait_vs(found, wt);
        dev[6] = cur_de;
        hsv[6] = cur_hs;
        for (int k = 5; k >= 0; k--) begin
            @(negedge clk);
            dev[k] = cur_de;
            hsv[k] = cur_hs;
        end
        chk("gap_de_pattern", 32'(dev), 32'(7'b1001001));
        chk("gap_hs_pattern", 32'(hsv), 32'(7'b1000000));
        idx = 6;
        do begin
            @(negedge clk);
            idx++;
        end while (cur_hs !== 1'b1 && idx < 100);
        chk("gap_line_period", 32'(idx), 32'd23);

        cp = 2'($urandom_range(0, 3)); cw = int'($urandom_range(1, 12));
        ch = int'($urandom_range(1, 6)); cc = 12'($urandom);
        apply_start(cp, cw, ch, cc);
        for (int f = 0; f < 5; f++) begin
            np = 2'($urandom_range(0, 3));
            nw = int'($urandom_range(1, 12));
            nh = int'($urandom_range(1, 6));
            nc = 12'($urandom);
            check_frame(1'b1, 2, cp, cw, ch, cc, np, nw, nh, f != 4, nc, wt);
            chk(f == 0 ? "gap_start_latency" : "gap_b2b", 32'(wt), (f == 0) ? 32'd2 : 32'd1);
            cp = np; cw = nw; ch = nh; cc = nc;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", errors + 1, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/video_stream_gen.md
Name: video_stream_gen

Overview:
- Video stream source that drives the pixel stream protocol consumed by the scaler chain: di/de/hs/vs.
- hs and vs are start-of-line and start-of-frame flags, qualified by de, on the first pixel.
- Generates test patterns with programmable active size, inter-pixel gaps and blanking.
- Used as the bench and bring-up stimulus source feeding scaler_h and later stages.

Parameters:
PIXEL_WIDTH, 12, pixel data width
HBLANK, 16, idle (de=0) cycles after each non-last line
VBLANK, 64, idle cycles after the last line of a frame
PIX_GAP, 0, idle cycles inserted between consecutive pixels of a line (0 = continuous)
CHK_SHIFT, 3, checker cell size = 2^CHK_SHIFT pixels/lines

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
en  in  1  run enable; sampled at frame boundaries
pattern_sel  in  2  0=horizontal ramp, 1=vertical ramp, 2=checker, 3=constant
const_val  in  PIXEL_WIDTH  pixel value for pattern 3
width  in  16  active pixels per line
height  in  16  active lines per frame
do_o  out  PIXEL_WIDTH  pixel data
de_o  out  1  pixel valid
hs_o  out  1  start of line; only asserted with de_o on pixel x=0
vs_o  out  1  start of frame; only asserted with de_o and hs_o on pixel (0,0)
busy_o  out  1  high while a frame is in progress (any state except IDLE)

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters x=y=gap=0. Asserting rst mid-frame aborts immediately; outputs are 0 the same cycle (async). No partial line is emitted after release.
- FSM states:
  - IDLE: en=1 and width!=0 and height!=0 -> ACTIVE. width, height and pattern_sel are latched at this transition and held constant for the whole frame. A zero size keeps the FSM in IDLE.
  - ACTIVE: emits one pixel per (PIX_GAP+1) cycles. After pixel x=width-1: if y<height-1 -> HBLANK, else -> VBLANK.
  - HBLANK: exactly HBLANK cycles with de_o=0, then y++, x=0 -> ACTIVE.
  - VBLANK: exactly VBLANK cycles with de_o=0, then: if en=1 and size nonzero -> relatch -> ACTIVE (y=0); else -> IDLE.
- en is ignored mid-frame; a deassert completes the current frame including VBLANK.
- Outputs are registered. The first de_o is high on the 2nd rising edge after the edge that samples en=1 in IDLE.
- de_o is never high in consecutive cycles when PIX_GAP>0. hs_o/vs_o are never high while de_o=0.
- Line period is width + (width-1)*PIX_GAP + HBLANK cycles. Frame period is height lines, with VBLANK replacing the final HBLANK.
- Patterns, with x, y the 16-bit pixel/line indices:
  - ramp H: do_o = x[PIXEL_WIDTH-1:0], wrapping modulo 2^PIXEL_WIDTH.
  - ramp V: do_o = y[PIXEL_WIDTH-1:0], wrapping modulo 2^PIXEL_WIDTH.
  - checker: (x>>CHK_SHIFT ^ y>>CHK_SHIFT) bit0 ? all-ones : 0.
  - constant: const_val, sampled per pixel.
- do_o holds its last value while de_o=0. Consumers must ignore it.
- width=1: every pixel has hs_o=1 and PIX_GAP does not apply. height=1: VBLANK follows the sole line directly; no HBLANK.
- busy_o is 1 from the cycle after leaving IDLE until the cycle after VBLANK ends to IDLE.

Test Plan:
- Continuous line: width=4, height=2, PIX_GAP=0, HBLANK=16, pattern 0, en=1 -> line 0 de_o 4 cycles with do_o=0,1,2,3, hs_o+vs_o on first; 16 idle; line 1 do_o=0..3, hs_o only on first; then 64 idle cycles.
- Gapped stream: PIX_GAP=2, width=3 -> de_o pattern 1,0,0,1,0,0,1 then HBLANK; hs_o only on the first pixel; line period 3+4+16=23 cycles.
- Checker/vertical: pattern 2, CHK_SHIFT=3, width=16, height=9 -> row 0 outputs 8x0 then 8x0xFFF; row 8 inverted. Pattern 1 -> all pixels of line 5 = 5.
- en drop mid-frame: deassert en during line 1 of 4 -> all 4 lines are emitted, VBLANK completes, busy_o falls, no further vs_o. Reassert en -> new frame starts with vs_o.
- Size boundaries: width=0 with en=1 -> stays IDLE, de_o=0 forever. width=1, height=1 -> single pixel with de_o=hs_o=vs_o=1, then VBLANK. width changed mid-frame -> no effect until the next frame.
- Reset mid-line: assert rst during pixel 2 of line 0 -> outputs 0 immediately. After release with en=1 -> a fresh frame starts at (0,0) with vs_o=1 and do_o=0 (pattern 0).
